// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through dcache write-port arbitration.
package wt_cache_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef struct packed {
    logic [11:0] address_index;
    logic [31:0] address_tag;
    logic [63:0] data_wdata;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    logic        data_req;
    logic        data_we;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wport_arb_state_e;

  function automatic int unsigned wport_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned WPORT_DEF_PORTS = 3;
  localparam int unsigned WPORT_IDX_W     = wport_idx_w(WPORT_DEF_PORTS);

endpackage

// File: rtl/wt_wport_rr_pick.sv
// Combinational round-robin picker with a lowest-index override for starved requesters.
module wt_wport_rr_pick #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned IdxW     = 2
) (
  input  logic [NumPorts-1:0] cand,
  input  logic [NumPorts-1:0] starved,
  input  logic [IdxW-1:0]     ptr,
  output logic [NumPorts-1:0] pick_onehot,
  output logic [IdxW-1:0]     pick_idx
);

  logic [NumPorts-1:0] starved_oh;
  logic [NumPorts-1:0] rr_oh;
  logic                rr_found;
  logic [IdxW-1:0]     rr_j;

  // Two's-complement trick isolates the lowest set bit.
  assign starved_oh = starved & (~starved + NumPorts'(1));

  always_comb begin
    rr_oh    = '0;
    rr_found = 1'b0;
    rr_j     = '0;
    for (int unsigned k = 1; k <= NumPorts; k++) begin
      rr_j = IdxW'((32'(ptr) + k) % NumPorts);
      if (!rr_found && cand[rr_j]) begin
        rr_oh[rr_j] = 1'b1;
        rr_found    = 1'b1;
      end
    end
  end

  assign pick_onehot = (|starved) ? starved_oh : rr_oh;

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (pick_onehot[i]) pick_idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/wt_dcache_wport_arb.sv
// Arbitrates LSU store ports onto the single wt_dcache write port: round-robin with
// anti-starvation, holding the chosen port until the cache grants it.
module wt_dcache_wport_arb
  import wt_cache_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
  parameter int unsigned NumPorts = WPORT_DEF_PORTS,
  parameter int unsigned MaxWait  = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             hold_i,
  input  dcache_req_i_t [NumPorts-1:0]     wr_req_i,
  output dcache_req_o_t [NumPorts-1:0]     wr_rsp_o,
  output dcache_req_i_t                    dc_req_o,
  input  dcache_req_o_t                    dc_rsp_i,
  output logic                             busy_o,
  output logic [$clog2(NumPorts)-1:0]      sel_idx_o
);

  localparam int unsigned IdxW  = $clog2(NumPorts);
  localparam int unsigned WaitW = $clog2(MaxWait + 1);
  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  if (NumPorts < 2 || MaxWait < 1 || CVA6Cfg.XLEN > 64) begin : g_param_check
    $error("wt_dcache_wport_arb: illegal parameter setting");
  end

  logic [0:0]          state_reg, state_next;
  logic [IdxW-1:0]     ptr_reg, ptr_next;
  logic [IdxW-1:0]     lock_idx_reg, lock_idx_next;

  logic [NumPorts-1:0] cand;
  logic [NumPorts-1:0] starved;
  logic [NumPorts-1:0] pick_onehot;
  logic [IdxW-1:0]     pick_idx;
  logic                locked, kill, any_cand;
  logic                fwd_valid, gnt;
  logic [IdxW-1:0]     fwd_idx;
  logic                unused_rsp;

  assign unused_rsp = dc_rsp_i.data_rvalid | (|dc_rsp_i.data_rdata) | (|pick_onehot);

  assign locked   = (state_reg == ST_LOCKED);
  assign any_cand = |cand;
  // A locked requester that drops data_req has withdrawn; the cache must not see it.
  assign kill      = locked & ~wr_req_i[lock_idx_reg].data_req;
  assign fwd_valid = locked ? ~kill : (any_cand & ~hold_i);
  assign fwd_idx   = locked ? lock_idx_reg : pick_idx;
  assign gnt       = fwd_valid & dc_rsp_i.data_gnt;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    logic [WaitW-1:0] wait_reg, wait_next;

    assign cand[gi]    = wr_req_i[gi].data_req & wr_req_i[gi].data_we;
    assign starved[gi] = cand[gi] & (wait_reg == WaitW'(MaxWait));

    always_comb begin
      wait_next = wait_reg;
      if (gnt && fwd_idx == IdxW'(gi)) begin
        wait_next = '0;
      end else if (kill && lock_idx_reg == IdxW'(gi)) begin
        wait_next = wait_reg;
      end else if (cand[gi]) begin
        wait_next = (wait_reg == WaitW'(MaxWait)) ? wait_reg : wait_reg + WaitW'(1);
      end else begin
        wait_next = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wait_reg <= '0;
      else         wait_reg <= wait_next;
    end
  end

  wt_wport_rr_pick #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) u_pick (
    .cand        (cand),
    .starved     (starved),
    .ptr         (ptr_reg),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lock_idx_next = lock_idx_reg;
    if (gnt) ptr_next = fwd_idx;
    if (locked) begin
      if (gnt || kill) state_next = ST_IDLE;
    end else if (fwd_valid && !gnt) begin
      state_next    = ST_LOCKED;
      lock_idx_next = pick_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= IdxW'(NumPorts - 1);
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  // Outputs are gated by rst_ni so they read zero for the whole reset pulse.
  always_comb begin
    dc_req_o = '0;
    if (rst_ni && fwd_valid) dc_req_o = wr_req_i[fwd_idx];
  end

  always_comb begin
    wr_rsp_o = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      wr_rsp_o[i].data_gnt = rst_ni & gnt & (fwd_idx == IdxW'(i));
    end
  end

  assign busy_o    = rst_ni & (locked | any_cand);
  assign sel_idx_o = rst_ni ? fwd_idx : '0;

endmodule

// File: tb/tb_wt_dcache_wport_arb.sv
// Directed bench for wt_dcache_wport_arb (3 ports, MaxWait=2) with an expectation queue.
module tb_wt_dcache_wport_arb;
  import wt_cache_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned MW = 2;

  logic                     clk_i  = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     hold_i = 1'b0;
  dcache_req_i_t [NP-1:0]   wr_req_i = '0;
  dcache_req_o_t [NP-1:0]   wr_rsp_o;
  dcache_req_i_t            dc_req_o;
  dcache_req_o_t            dc_rsp_i = '0;
  logic                     busy_o;
  logic [WPORT_IDX_W-1:0]   sel_idx_o;

  wt_dcache_wport_arb #(
    .CVA6Cfg  (cva6_cfg_empty),
    .NumPorts (NP),
    .MaxWait  (MW)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .hold_i    (hold_i),
    .wr_req_i  (wr_req_i),
    .wr_rsp_o  (wr_rsp_o),
    .dc_req_o  (dc_req_o),
    .dc_rsp_i  (dc_rsp_i),
    .busy_o    (busy_o),
    .sel_idx_o (sel_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    int         port;
    logic [2:0] gnt;
    logic       busy;
    int         sel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // One clock of stimulus: drive after the rising edge, compare on the falling edge.
  task automatic step(input string tag, input logic rst, input logic [2:0] wr,
                      input logic [2:0] rd, input logic hold, input logic cgnt,
                      input int eport, input logic [2:0] egnt, input logic ebusy,
                      input int esel);
    exp_t       e;
    int         o_port;
    logic [2:0] o_gnt;
    @(posedge clk_i);
    #1;
    rst_ni = rst;
    hold_i = hold;
    dc_rsp_i = '0;
    dc_rsp_i.data_gnt = cgnt;
    for (int p = 0; p < NP; p++) begin
      wr_req_i[p]             = '0;
      wr_req_i[p].address_tag = 32'(p + 1);
      wr_req_i[p].data_wdata  = {32'hD00D_0000, 32'(p)};
      wr_req_i[p].data_req    = wr[p] | rd[p];
      wr_req_i[p].data_we     = wr[p];
    end
    exp_q.push_back('{tag, eport, egnt, ebusy, esel});
    @(negedge clk_i);
    vectors++;
    assert (exp_q.size() > 0) else begin
      miscompares++;
      $error("FAIL %s queue_empty got 0 entries exp 1", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o_port = dc_req_o.data_req ? int'(dc_req_o.address_tag) - 1 : -1;
      for (int p = 0; p < NP; p++) o_gnt[p] = wr_rsp_o[p].data_gnt;
      vectors++;
      assert (o_port === e.port) else begin
        miscompares++;
        $error("FAIL %s fwd_port got %0d exp %0d", e.tag, o_port, e.port);
      end
      vectors++;
      assert (o_gnt === e.gnt) else begin
        miscompares++;
        $error("FAIL %s gnt_vec got %b exp %b", e.tag, o_gnt, e.gnt);
      end
      vectors++;
      assert (busy_o === e.busy) else begin
        miscompares++;
        $error("FAIL %s busy got %b exp %b", e.tag, busy_o, e.busy);
      end
      vectors++;
      assert (int'(sel_idx_o) === e.sel) else begin
        miscompares++;
        $error("FAIL %s sel_idx got %0d exp %0d", e.tag, sel_idx_o, e.sel);
      end
      $display("txn %-10s wr=%b rd=%b hold=%b cgnt=%b -> fwd=%0d gnt=%b busy=%b sel=%0d",
               e.tag, wr, rd, hold, cgnt, o_port, o_gnt, busy_o, sel_idx_o);
    end
  endtask

  initial begin
    // reset, including requests and a cache grant while reset is low
    step("rst_idle",  0, 3'b000, 3'b000, 0, 0, -1, 3'b000, 0, 0);
    step("rst_req",   0, 3'b111, 3'b000, 0, 1, -1, 3'b000, 0, 0);
    // 1: all three request, grant every cycle -> 0,1,2
    step("t1_a",      1, 3'b111, 3'b000, 0, 1,  0, 3'b001, 1, 0);
    step("t1_b",      1, 3'b110, 3'b000, 0, 1,  1, 3'b010, 1, 1);
    step("t1_c",      1, 3'b100, 3'b000, 0, 1,  2, 3'b100, 1, 2);
    // 2: port 1 locked for three cycles, port 0 arrives, waits its turn
    step("t2_a",      1, 3'b010, 3'b000, 0, 0,  1, 3'b000, 1, 1);
    step("t2_b",      1, 3'b010, 3'b000, 0, 0,  1, 3'b000, 1, 1);
    step("t2_c",      1, 3'b010, 3'b000, 0, 0,  1, 3'b000, 1, 1);
    step("t2_d",      1, 3'b011, 3'b000, 0, 1,  1, 3'b010, 1, 1);
    step("t2_e",      1, 3'b001, 3'b000, 0, 1,  0, 3'b001, 1, 0);
    // 3: lock on port 2, then it withdraws; a stray grant must not be routed
    step("t3_lock",   1, 3'b100, 3'b000, 0, 0,  2, 3'b000, 1, 2);
    step("t3_kill",   1, 3'b010, 3'b000, 0, 1, -1, 3'b000, 1, 2);
    step("t3_rr",     1, 3'b111, 3'b000, 0, 1,  1, 3'b010, 1, 1);
    step("t3_d",      1, 3'b101, 3'b000, 0, 1,  2, 3'b100, 1, 2);
    step("t3_e",      1, 3'b001, 3'b000, 0, 1,  0, 3'b001, 1, 0);
    step("t3_read",   1, 3'b000, 3'b001, 0, 0, -1, 3'b000, 0, 0);
    // 4: port 2 starves behind a locked port 0, then beats the RR choice (port 1)
    step("t4_lock",   1, 3'b001, 3'b000, 0, 0,  0, 3'b000, 1, 0);
    step("t4_b",      1, 3'b101, 3'b000, 0, 0,  0, 3'b000, 1, 0);
    step("t4_c",      1, 3'b101, 3'b000, 0, 0,  0, 3'b000, 1, 0);
    step("t4_d",      1, 3'b101, 3'b000, 0, 1,  0, 3'b001, 1, 0);
    step("t4_starve", 1, 3'b110, 3'b000, 0, 1,  2, 3'b100, 1, 2);
    step("t4_f",      1, 3'b010, 3'b000, 0, 1,  1, 3'b010, 1, 1);
    // 5: hold blocks new arbitration but not a locked transfer
    step("t5_hold",   1, 3'b001, 3'b000, 1, 1, -1, 3'b000, 1, 0);
    step("t5_lock",   1, 3'b001, 3'b000, 0, 0,  0, 3'b000, 1, 0);
    step("t5_hold_l", 1, 3'b001, 3'b000, 1, 1,  0, 3'b001, 1, 0);
    // 6: reset while locked, then port 0 wins first
    step("t6_lock",   1, 3'b100, 3'b000, 0, 0,  2, 3'b000, 1, 2);
    step("t6_rst",    0, 3'b100, 3'b000, 0, 1, -1, 3'b000, 0, 0);
    step("t6_first",  1, 3'b111, 3'b000, 0, 1,  0, 3'b001, 1, 0);
    step("t6_idle",   1, 3'b000, 3'b000, 0, 0, -1, 3'b000, 0, 0);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL leftover_queue got %0d entries exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
